bus_xfer_seq: RTL
=================

BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 Port reset  in  1  asynchronous, active-high reset.
REQ-003 Port req  in  1  transfer request; sampled only in IDLE.
REQ-004 Port wr  in  1  1 = write transfer, 0 = read; latched on accept.
REQ-005 Port xsize  in  2  transfer width: 0 = 8, 1 = 16, 2 = 32, 3 = 64 bit; latched on accept.
REQ-006 Port xaddr  in  3  byte offset within the 64-bit phrase; latched on accept.
REQ-007 Port mws  in  2  external memory width, same encoding as xsize; latched on accept.
REQ-008 Port ack  in  1  external cycle acknowledge; sampled only in WAIT.
REQ-009 Port busy  out  1  high in every state except IDLE.
REQ-010 Port start  out  1  one-cycle pulse per external bus cycle.
REQ-011 Port ba  out  3  byte address offset of the current beat.
REQ-012 Port beat  out  3  index of the current beat, starting at 0.
REQ-013 Port rd  out  1  latched copy of wr, inverted; valid while busy.
REQ-014 Port done  out  1  one-cycle completion pulse.
REQ-015 Port err  out  1  one-cycle timeout pulse; constant 0 when BUS_WDOG_EN is undefined.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE, with one-hot or binary encoding free.
REQ-017 On a rising edge in IDLE with req=1, the block SHALL latch wr, xsize, xaddr and mws and enter ISSUE.
REQ-018 The beat count SHALL be 2^(xsize-mws) when xsize > mws, else 1 (range 1..8).
REQ-019 The first ba SHALL be xaddr with its low xsize bits cleared (xsize 0: none; 1: bit 0; 2: bits 1:0; 3: bits 2:0).
REQ-020 In ISSUE, start SHALL be 1 for exactly one cycle and the FSM SHALL then enter WAIT unconditionally.
REQ-021 In WAIT, ack=1 at an edge SHALL enter DONE if this is the last beat; otherwise it SHALL enter ISSUE with ba += 2^mws (mod 8) and beat += 1.
REQ-022 ack in IDLE, ISSUE or DONE SHALL be ignored.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE; req during DONE SHALL be ignored.
REQ-024 The end-of-transfer test SHALL use a remaining-beat down-counter rather than beat, so an 8-beat transfer terminates correctly although beat wraps at 8.
REQ-025 Minimum latency: a 1-beat transfer with ack in the first WAIT cycle SHALL have done high 3 cycles after the req-accept edge.
REQ-026 ba and beat SHALL hold stable from ISSUE through WAIT for each beat.

Reset
REQ-027 While reset=1 the FSM SHALL be in IDLE with busy, start, done and err at 0; ba, beat and rd at 0; all latched fields and counters at 0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately with no done or err pulse.

Configuration
REQ-029 With macro BUS_WDOG_EN defined, an 8-bit watchdog SHALL clear on each WAIT entry and count each WAIT cycle.
REQ-030 With BUS_WDOG_EN defined, when the watchdog reaches 255 without ack, the FSM SHALL enter DONE with err and done both pulsed in the same cycle, and remaining beats SHALL be abandoned.
REQ-031 Without BUS_WDOG_EN, no watchdog logic SHALL exist, err SHALL be tied to 0, and WAIT SHALL last indefinitely.

Verification
REQ-032 Scenario: xsize=3, mws=1, xaddr=5, wr=1, ack one cycle after each start -> 4 start pulses with ba = 0, 2, 4, 6 and beat = 0..3; rd=0; one done.
REQ-033 Scenario: xsize=0, mws=3, xaddr=6 -> 1 beat with ba=6; done 3 cycles after accept.
REQ-034 Scenario: xsize=3, mws=0 -> 8 beats with ba = 0..7, beat wraps to 0 only after done; exactly one done.
REQ-035 Scenario: ack held high throughout a 2-beat transfer -> starts spaced 2 cycles apart; ack during ISSUE has no effect.
REQ-036 Scenario: reset pulsed during beat 2 of 4 -> busy=0 and state IDLE immediately, no done; the next req is accepted normally.
REQ-037 Scenario (BUS_WDOG_EN): ack never asserted -> err=done=1 on the same cycle, 256 cycles after WAIT entry, then IDLE.

Source files
------------

// File: rtl/bus_xfer_seq_if.sv
// Handshake and beat-address signals between a transfer requester and bus_xfer_seq.
// The requester side also drives the external acknowledge.
interface bus_xfer_seq_if;
  logic       req;
  logic       wr;
  logic [1:0] xsize;
  logic [2:0] xaddr;
  logic [1:0] mws;
  logic       ack;
  logic       busy;
  logic       start;
  logic [2:0] ba;
  logic [2:0] beat;
  logic       rd;
  logic       done;
  logic       err;

  modport master (
    output req, wr, xsize, xaddr, mws, ack,
    input  busy, start, ba, beat, rd, done, err
  );

  modport slave (
    input  req, wr, xsize, xaddr, mws, ack,
    output busy, start, ba, beat, rd, done, err
  );
endinterface

// File: rtl/bus_xfer_seq.sv
// Splits one 8..64-bit transfer into external bus beats sized by the memory width.
// Optional wait-state watchdog enabled by defining BUS_WDOG_EN.
module bus_xfer_seq (
  input logic           clk,
  input logic           reset,
  bus_xfer_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e     state_q;
  logic       busy_q;
  logic       start_q;
  logic       done_q;
  logic       rd_q;
  logic [1:0] mws_q;
  logic [2:0] ba_q;
  logic [2:0] beat_q;
  logic [2:0] rem_q;

  logic [2:0] first_rem;
  logic [2:0] first_ba;
  logic [2:0] size_mask;
  logic [2:0] step;

  // First beat address is aligned to the transfer size; beats-1 preloads the down-counter.
  always_comb begin
    first_rem = 3'd0;
    if (bus.xsize > bus.mws) begin
      first_rem = 3'((4'd1 << (bus.xsize - bus.mws)) - 4'd1);
    end
    size_mask = 3'((4'd1 << bus.xsize) - 4'd1);
    first_ba  = bus.xaddr & ~size_mask;
    step      = 3'(4'd1 << mws_q);
  end

`ifdef BUS_WDOG_EN
  logic [7:0] wdog_q;
  logic       err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      mws_q   <= 2'd0;
      ba_q    <= 3'd0;
      beat_q  <= 3'd0;
      rem_q   <= 3'd0;
`ifdef BUS_WDOG_EN
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef BUS_WDOG_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            state_q <= StIssue;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            rd_q    <= ~bus.wr;
            mws_q   <= bus.mws;
            ba_q    <= first_ba;
            beat_q  <= 3'd0;
            rem_q   <= first_rem;
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef BUS_WDOG_EN
          wdog_q  <= 8'd0;
`endif
        end
        StWait: begin
          if (bus.ack) begin
            // rem_q, not beat_q, decides the end so 8-beat transfers survive beat wrap.
            if (rem_q == 3'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
              start_q <= 1'b1;
              ba_q    <= ba_q + step;
              beat_q  <= beat_q + 3'd1;
              rem_q   <= rem_q - 3'd1;
            end
          end
`ifdef BUS_WDOG_EN
          else if (wdog_q == 8'hff) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            wdog_q  <= wdog_q + 8'd1;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          beat_q  <= 3'd0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.start = start_q;
  assign bus.ba    = ba_q;
  assign bus.beat  = beat_q;
  assign bus.rd    = rd_q;
  assign bus.done  = done_q;
`ifdef BUS_WDOG_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule
